// File: rtl/voice_pkg.sv
// Shared constants and message decode for the polyphonic voice allocator.
package voice_pkg;

    localparam int unsigned MSG_W      = 24;
    localparam int unsigned STATUS_LSB = 16;
    localparam int unsigned DATA1_LSB  = 8;
    localparam int unsigned DATA2_LSB  = 0;
    localparam int unsigned NOTE_W     = 7;
    localparam int unsigned AGE_W      = 4;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned CNT_W      = 8;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CC       = 4'hB;

    localparam logic [NOTE_W-1:0] CC_SUSTAIN       = 7'd64;
    localparam logic [NOTE_W-1:0] CC_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [1:0] {
        MSG_NOTE_ON  = 2'd0,
        MSG_NOTE_OFF = 2'd1,
        MSG_SUSTAIN  = 2'd2,
        MSG_ALL_OFF  = 2'd3
    } msg_kind_e;

    typedef struct packed {
        logic              valid;
        msg_kind_e         kind;
        logic [NOTE_W-1:0] note;
        logic [NOTE_W-1:0] value;
    } voice_cmd_t;

    // Classify a message; anything the allocator does not act on comes back invalid.
    function automatic voice_cmd_t decode_msg(input logic [3:0]        status,
                                              input logic [NOTE_W-1:0] data1,
                                              input logic [NOTE_W-1:0] data2);
        voice_cmd_t cmd;
        cmd       = '0;
        cmd.note  = data1;
        cmd.value = data2;
        case (status)
            ST_NOTE_ON: begin
                cmd.valid = 1'b1;
                cmd.kind  = (data2 != '0) ? MSG_NOTE_ON : MSG_NOTE_OFF;
            end
            ST_NOTE_OFF: begin
                cmd.valid = 1'b1;
                cmd.kind  = MSG_NOTE_OFF;
            end
            ST_CC: begin
                if (data1 == CC_SUSTAIN) begin
                    cmd.valid = 1'b1;
                    cmd.kind  = MSG_SUSTAIN;
                end else if (data1 == CC_ALL_NOTES_OFF) begin
                    cmd.valid = 1'b1;
                    cmd.kind  = MSG_ALL_OFF;
                end
            end
            default: cmd.valid = 1'b0;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// MIDI input and per-voice output bundle of the voice allocator.
interface voice_allocator_if #(
    parameter int unsigned NUM_VOICES = 8
);
    logic [23:0]             midi_msg;
    logic                    midi_msg_rdy;
    logic [7*NUM_VOICES-1:0] voice_note;
    logic [7*NUM_VOICES-1:0] voice_vel;
    logic [NUM_VOICES-1:0]   voice_gate;
    logic [NUM_VOICES-1:0]   voice_trig;
    logic                    busy;
    logic [7:0]              drop_cnt;

    modport master (
        output midi_msg, midi_msg_rdy,
        input  voice_note, voice_vel, voice_gate, voice_trig, busy, drop_cnt
    );

    modport slave (
        input  midi_msg, midi_msg_rdy,
        output voice_note, voice_vel, voice_gate, voice_trig, busy, drop_cnt
    );
endinterface

// File: rtl/voice_age_tracker.sv
// LRU age permutation over the voices; reports which voice is currently the oldest.
module voice_age_tracker
    import voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             assign_en_i,
    input  logic [IDX_W-1:0] assign_idx_i,
    output logic [IDX_W-1:0] oldest_idx_o
);

    logic [AGE_W-1:0] age_q [NUM_VOICES];
    logic [AGE_W-1:0] age_d [NUM_VOICES];
    logic [IDX_W-1:0] oldest_q;
    logic [IDX_W-1:0] oldest_d;
    logic [AGE_W-1:0] sel_age_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                age_q[i] <= AGE_W'(NUM_VOICES - 1 - i);
            end
            oldest_q <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                age_q[i] <= age_d[i];
            end
            oldest_q <= oldest_d;
        end
    end

    // Younger-than-assigned voices age by one; the assigned voice becomes youngest.
    always_comb begin
        sel_age_c = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            age_d[i] = age_q[i];
            if (IDX_W'(i) == assign_idx_i) begin
                sel_age_c = age_q[i];
            end
        end
        if (assign_en_i) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == assign_idx_i) begin
                    age_d[i] = '0;
                end else if (age_q[i] < sel_age_c) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
        oldest_d = oldest_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (age_d[i] == AGE_W'(NUM_VOICES - 1)) begin
                oldest_d = IDX_W'(i);
            end
        end
    end

    assign oldest_idx_o = oldest_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic MIDI voice allocator: latches one message, scans voices, commits in one cycle.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned OMNI       = 1,
    parameter int unsigned CHANNEL    = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    voice_allocator_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    voice_cmd_t        cmd_q, cmd_d;
    logic              match_found_q, match_found_d;
    logic [IDX_W-1:0]  match_idx_q, match_idx_d;
    logic              free_found_q, free_found_d;
    logic [IDX_W-1:0]  free_idx_q, free_idx_d;
    logic [NOTE_W-1:0] note_q [NUM_VOICES];
    logic [NOTE_W-1:0] note_d [NUM_VOICES];
    logic [NOTE_W-1:0] vel_q  [NUM_VOICES];
    logic [NOTE_W-1:0] vel_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] held_q, held_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic              sustain_q, sustain_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    voice_cmd_t        in_cmd_c;
    logic              chan_ok_c;
    logic              cur_gate_c;
    logic [NOTE_W-1:0] cur_note_c;
    logic [IDX_W-1:0]  target_c;
    logic              age_en_c;
    logic [IDX_W-1:0]  age_idx_c;
    logic [IDX_W-1:0]  oldest_idx_c;
    logic              unused_msg_bits_c;

    assign in_cmd_c = decode_msg(bus.midi_msg[STATUS_LSB+4 +: 4],
                                 bus.midi_msg[DATA1_LSB +: NOTE_W],
                                 bus.midi_msg[DATA2_LSB +: NOTE_W]);
    assign chan_ok_c = (OMNI != 0) || (bus.midi_msg[STATUS_LSB +: 4] == 4'(CHANNEL));
    assign unused_msg_bits_c = ^{bus.midi_msg[DATA1_LSB+7], bus.midi_msg[DATA2_LSB+7]};

    voice_age_tracker #(.NUM_VOICES(NUM_VOICES)) u_age (
        .clk         (CLK),
        .rst_n       (nRST),
        .assign_en_i (age_en_c),
        .assign_idx_i(age_idx_c),
        .oldest_idx_o(oldest_idx_c)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            scan_idx_q    <= '0;
            cmd_q         <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
            end
            gate_q    <= '0;
            held_q    <= '0;
            trig_q    <= '0;
            sustain_q <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            cmd_q         <= cmd_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= note_d[i];
                vel_q[i]  <= vel_d[i];
            end
            gate_q    <= gate_d;
            held_q    <= held_d;
            trig_q    <= trig_d;
            sustain_q <= sustain_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        cmd_d         = cmd_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            note_d[i] = note_q[i];
            vel_d[i]  = vel_q[i];
        end
        gate_d     = gate_q;
        held_d     = held_q;
        trig_d     = '0;
        sustain_d  = sustain_q;
        drop_d     = drop_q;
        age_en_c   = 1'b0;
        age_idx_c  = '0;
        cur_gate_c = 1'b0;
        cur_note_c = '0;

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == scan_idx_q) begin
                cur_gate_c = gate_q[i];
                cur_note_c = note_q[i];
            end
        end
        // Retrigger beats a free voice, which beats stealing the oldest.
        target_c = match_found_q ? match_idx_q :
                   free_found_q  ? free_idx_q  : oldest_idx_c;

        if ((state_q != IDLE) && bus.midi_msg_rdy && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.midi_msg_rdy && in_cmd_c.valid && chan_ok_c) begin
                    cmd_d         = in_cmd_c;
                    state_d       = SCAN;
                    scan_idx_d    = '0;
                    match_found_d = 1'b0;
                    match_idx_d   = '0;
                    free_found_d  = 1'b0;
                    free_idx_d    = '0;
                end
            end
            SCAN: begin
                if (cur_gate_c && (cur_note_c == cmd_q.note) && !match_found_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_idx_q;
                end
                if (!cur_gate_c && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                if (scan_idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = COMMIT;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (cmd_q.valid) begin
                    case (cmd_q.kind)
                        MSG_NOTE_ON: begin
                            age_en_c  = 1'b1;
                            age_idx_c = target_c;
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IDX_W'(i) == target_c) begin
                                    note_d[i] = cmd_q.note;
                                    vel_d[i]  = cmd_q.value;
                                    gate_d[i] = 1'b1;
                                    held_d[i] = 1'b0;
                                    trig_d[i] = 1'b1;
                                end
                            end
                        end
                        MSG_NOTE_OFF: begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (gate_q[i] && (note_q[i] == cmd_q.note)) begin
                                    if (sustain_q) begin
                                        held_d[i] = 1'b1;
                                    end else begin
                                        gate_d[i] = 1'b0;
                                    end
                                end
                            end
                        end
                        MSG_SUSTAIN: begin
                            if (cmd_q.value[6]) begin
                                sustain_d = 1'b1;
                            end else begin
                                sustain_d = 1'b0;
                                gate_d    = gate_q & ~held_q;
                                held_d    = '0;
                            end
                        end
                        MSG_ALL_OFF: begin
                            gate_d    = '0;
                            held_d    = '0;
                            sustain_d = 1'b0;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign bus.voice_note[7*g +: 7] = note_q[g];
        assign bus.voice_vel[7*g +: 7]  = vel_q[g];
    end
    assign bus.voice_gate = gate_q;
    assign bus.voice_trig = trig_q;
    assign bus.busy       = busy_q;
    assign bus.drop_cnt   = drop_q;

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 8, SHALL set voice count; legal range 2..16.
REQ-002 Parameter OMNI, default 1, SHALL accept all MIDI channels when 1.
REQ-003 Parameter CHANNEL, default 0, SHALL set the only accepted channel (0..15) when OMNI=0.
REQ-004 CLK  in  1  SHALL be the single clock; all state on rising edge.
REQ-005 nRST  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 midi_msg  in  24  SHALL carry [23:16] status, [15:8] data1, [7:0] data2.
REQ-007 midi_msg_rdy  in  1  SHALL be a one-cycle strobe qualifying midi_msg.
REQ-008 voice_note  out  7*NUM_VOICES  SHALL give note number per voice, voice i at [7i+6:7i].
REQ-009 voice_vel  out  7*NUM_VOICES  SHALL give velocity per voice, same packing.
REQ-010 voice_gate  out  NUM_VOICES  SHALL be high while a voice sounds or is held by sustain.
REQ-011 voice_trig  out  NUM_VOICES  SHALL pulse one cycle on each (re)assignment.
REQ-012 busy  out  1  SHALL be high whenever the FSM is not IDLE.
REQ-013 drop_cnt  out  8  SHALL count messages dropped while busy, saturating at 255.

Function
REQ-014 FSM states SHALL be IDLE, SCAN, COMMIT; IDLE->SCAN on accepted strobe, SCAN steps voice index 0..NUM_VOICES-1 one per cycle, then COMMIT for one cycle, then IDLE.
REQ-015 A strobe in IDLE SHALL latch midi_msg; a strobe in SCAN/COMMIT SHALL be discarded and increment drop_cnt.
REQ-016 Messages failing the channel filter, or with unrecognised status, SHALL be ignored without entering SCAN.
REQ-017 Outputs SHALL update in COMMIT: strobe at cycle t -> new voice_* values and voice_trig pulse visible at t+NUM_VOICES+2.
REQ-018 Note-on (status 0x9n, data2>0): a voice with gate=1 and equal note SHALL be retriggered (vel updated, trig pulsed, held cleared).
REQ-019 Otherwise the lowest-index voice with gate=0 SHALL be assigned.
REQ-020 With no free voice, the voice with age NUM_VOICES-1 (oldest) SHALL be stolen.
REQ-021 Ages SHALL form a permutation 0..NUM_VOICES-1; on assignment of voice v, every voice with age<age[v] increments and age[v] becomes 0.
REQ-022 Note-off (status 0x8n, or 0x9n with data2=0) SHALL, for every gated voice with matching note, clear gate if sustain off, else set held.
REQ-023 CC 64 (status 0xBn): data2>=64 SHALL set sustain; data2<64 SHALL clear sustain and clear gate of every held voice.
REQ-024 CC 123 SHALL clear all gates, all held flags and sustain; ages unchanged.
REQ-025 voice_note and voice_vel SHALL retain values after gate clears; data1/data2 use bits [6:0] only.
REQ-026 At most one voice_trig bit SHALL be high in any cycle.

Reset
REQ-027 nRST low SHALL immediately force IDLE, gates/trig/held/sustain 0, notes/vels 0, busy 0, drop_cnt 0, age[i]=NUM_VOICES-1-i.
REQ-028 Reset mid-SCAN SHALL abandon the latched message with no output change after release.

Structure
REQ-029 Package voice_pkg SHALL hold status nibble constants (NOTE_OFF 0x8, NOTE_ON 0x9, CC 0xB), CC numbers 64 and 123, and message field positions.
REQ-030 Age bookkeeping SHALL be one sub-module, voice_age_tracker (assign index in, oldest index out).

Verification
REQ-031 Note-on 0x90/60/100 after reset -> voice 0 note 60 vel 100 gate 1, trig[0] pulse at t+10.
REQ-032 Nine note-ons 60..68 -> note 68 steals voice 0 (oldest), trig[0] pulses, voices 1..7 unchanged.
REQ-033 Note-on 0x90/60/100, then 0x90/60/0 -> gate[0] 0, note 60 retained.
REQ-034 CC 0xB0/64/127, note-off 60, CC 0xB0/64/0 -> gate[0] stays 1 until sustain release, then 0.
REQ-035 Two strobes 3 cycles apart -> second ignored, drop_cnt 1; OMNI=0 CHANNEL=2 with 0x91 -> no change.
REQ-036 nRST pulse during SCAN -> all outputs reset values, no trig after release.
